// File: rtl/avalon_tx_fifo_csr.sv
// Avalon-MM slave CSR block feeding a show-ahead TX FIFO that drains to a valid/ready stream.
// DATA pushes, STATUS/CONTROL/TXCNT expose FIFO state; waitrequest stalls DATA writes while full.
module avalon_tx_fifo_csr #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 2,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [AWIDTH-1:0] avs_address,
  input  logic              avs_write,
  input  logic [DWIDTH-1:0] avs_writedata,
  input  logic              avs_read,
  output logic              avs_waitrequest,
  output logic [DWIDTH-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic [DWIDTH-1:0] st_data_o,
  output logic              st_valid_o,
  input  logic              st_ready_i
);

  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [AWIDTH-1:0] REG_DATA   = AWIDTH'(0);
  localparam logic [AWIDTH-1:0] REG_STATUS = AWIDTH'(1);
  localparam logic [AWIDTH-1:0] REG_CTRL   = AWIDTH'(2);
  localparam logic [AWIDTH-1:0] REG_TXCNT  = AWIDTH'(3);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       used;
  logic              enable;
  logic [31:0]       txcnt;

  logic              full;
  logic              empty;
  logic              wr_acc;
  logic              push;
  logic              pop;
  logic              ctrl_wr;
  logic              clr;
  logic              txcnt_wr;
  logic              rd_acc;
  logic [DWIDTH-1:0] rd_mux;

  assign full            = (used == (PW+1)'(DEPTH));
  assign empty           = (used == '0);
  assign avs_waitrequest = avs_write & (avs_address == REG_DATA) & full;
  assign wr_acc          = avs_write & ~avs_waitrequest;
  assign push            = wr_acc & (avs_address == REG_DATA);
  assign ctrl_wr         = wr_acc & (avs_address == REG_CTRL);
  assign clr             = ctrl_wr & avs_writedata[1];
  assign txcnt_wr        = wr_acc & (avs_address == REG_TXCNT);
  // A read issued alongside a write is dropped entirely.
  assign rd_acc          = avs_read & ~avs_write;

  assign st_valid_o = enable & ~empty;
  assign pop        = st_valid_o & st_ready_i;
  assign st_data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= avs_writedata;
    end
  end

  // Clear overrides any pop on the same edge; push and clear never coincide.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      used   <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      used   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   used <= used + (PW+1)'(1);
        2'b01:   used <= used - (PW+1)'(1);
        default: used <= used;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      enable <= 1'b0;
      txcnt  <= '0;
    end else begin
      if (ctrl_wr) enable <= avs_writedata[0];
      if (txcnt_wr) begin
        txcnt <= '0;
      end else if (pop && !clr) begin
        txcnt <= txcnt + 32'd1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      REG_STATUS: begin
        rd_mux[15:0] = 16'(used);
        rd_mux[16]   = empty;
        rd_mux[17]   = full;
      end
      REG_CTRL:  rd_mux[0] = enable;
      REG_TXCNT: rd_mux = DWIDTH'(txcnt);
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= rd_acc;
      if (rd_acc) avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_avalon_tx_fifo_csr.sv
// Directed bench for avalon_tx_fifo_csr: register map, stall on full, stream order,
// clear semantics, TXCNT wrap/reset, read/write collision and asynchronous reset.
module tb_avalon_tx_fifo_csr;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [1:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [31:0] st_data_o;
  logic        st_valid_o;
  logic        st_ready_i;

  int n_assert = 0;
  int n_fail   = 0;
  int stalls;
  logic [31:0] popped [$];

  avalon_tx_fifo_csr #(.DWIDTH(32), .AWIDTH(2), .DEPTH(8)) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .avs_address       (avs_address),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_read          (avs_read),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .st_data_o         (st_data_o),
    .st_valid_o        (st_valid_o),
    .st_ready_i        (st_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Record every word the stream hands over; inputs are settled by negedge+2.
  always @(negedge clk_i) begin
    #2;
    if (st_valid_o === 1'b1 && st_ready_i === 1'b1) popped.push_back(st_data_o);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, output int st);
    avs_address   = a;
    avs_write     = 1'b1;
    avs_writedata = d;
    st = 0;
    #1;
    while (avs_waitrequest === 1'b1 && st < 20) begin
      @(negedge clk_i);
      #1;
      st++;
    end
    chk("wr_timeout", 64'(st < 20), 64'd1);
    @(negedge clk_i);
    avs_write = 1'b0;
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk_i);
    avs_read = 1'b0;
    #1;
    chk({tag, "_rdv"}, 64'(avs_readdatavalid), 64'd1);
    chk(tag, 64'(avs_readdata), 64'(exp));
  endtask

  initial begin
    rst_n_i       = 1'b0;
    avs_address   = '0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    avs_read      = 1'b0;
    st_ready_i    = 1'b0;

    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_rdv",   64'(avs_readdatavalid), 64'd0);
    chk("rst_rdata", 64'(avs_readdata),      64'd0);
    chk("rst_valid", 64'(st_valid_o),        64'd0);
    chk("rst_wait",  64'(avs_waitrequest),   64'd0);
    rst_n_i = 1'b1;

    rd(2'd1, 32'h0001_0000, "status_reset");
    @(negedge clk_i);
    #1;
    chk("rdv_one_pulse", 64'(avs_readdatavalid), 64'd0);
    chk("valid_after_reset", 64'(st_valid_o), 64'd0);

    for (int i = 0; i < 8; i++) wr(2'd0, 32'hA1 + 32'(i), stalls);
    chk("valid_disabled", 64'(st_valid_o), 64'd0);
    rd(2'd1, 32'h0002_0008, "status_full");

    avs_address   = 2'd0;
    avs_write     = 1'b1;
    avs_writedata = 32'hA9;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("wait_full", 64'(avs_waitrequest), 64'd1);
      @(negedge clk_i);
      #1;
    end
    avs_write = 1'b0;
    #1;
    chk("wait_released", 64'(avs_waitrequest), 64'd0);

    popped.delete();
    wr(2'd2, 32'h1, stalls);
    st_ready_i = 1'b1;
    wr(2'd0, 32'hA9, stalls);
    chk("ninth_stall_cycles", 64'(stalls), 64'd1);
    repeat (12) @(negedge clk_i);
    #1;
    st_ready_i = 1'b0;
    chk("pop_count", 64'(popped.size()), 64'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < popped.size()) chk("pop_order", 64'(popped[i]), 64'hA1 + 64'(i));
    end
    chk("drained_valid", 64'(st_valid_o), 64'd0);
    rd(2'd3, 32'd9, "txcnt_nine");

    wr(2'd0, 32'hB1, stalls);
    wr(2'd0, 32'hB2, stalls);
    wr(2'd0, 32'hB3, stalls);
    chk("valid_enabled", 64'(st_valid_o), 64'd1);
    chk("head_word", 64'(st_data_o), 64'hB1);
    st_ready_i = 1'b1;
    wr(2'd2, 32'h3, stalls);
    st_ready_i = 1'b0;
    rd(2'd1, 32'h0001_0000, "status_cleared");
    rd(2'd2, 32'h1, "ctrl_after_clear");
    chk("valid_after_clear", 64'(st_valid_o), 64'd0);
    rd(2'd3, 32'd9, "txcnt_clear_pop");

    wr(2'd0, 32'hC1, stalls);
    rd(2'd1, 32'h0000_0001, "status_one");
    force dut.txcnt = 32'hFFFF_FFFF;
    @(negedge clk_i);
    #1;
    release dut.txcnt;
    rd(2'd3, 32'hFFFF_FFFF, "txcnt_forced");
    st_ready_i = 1'b1;
    @(negedge clk_i);
    #1;
    st_ready_i = 1'b0;
    rd(2'd3, 32'd0, "txcnt_wrap");
    wr(2'd0, 32'hD1, stalls);
    st_ready_i = 1'b1;
    @(negedge clk_i);
    #1;
    st_ready_i = 1'b0;
    rd(2'd3, 32'd1, "txcnt_one");
    wr(2'd3, 32'h1234, stalls);
    rd(2'd3, 32'd0, "txcnt_write_zero");
    wr(2'd1, 32'hFFFF_FFFF, stalls);
    rd(2'd1, 32'h0001_0000, "status_ro");

    wr(2'd2, 32'h0, stalls);
    avs_address   = 2'd2;
    avs_writedata = 32'h1;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    @(negedge clk_i);
    avs_read  = 1'b0;
    avs_write = 1'b0;
    #1;
    chk("collide_no_rdv", 64'(avs_readdatavalid), 64'd0);
    rd(2'd2, 32'h1, "ctrl_after_collide");

    wr(2'd0, 32'hE1, stalls);
    chk("valid_before_rst", 64'(st_valid_o), 64'd1);
    avs_address = 2'd1;
    avs_read    = 1'b1;
    @(negedge clk_i);
    avs_read = 1'b0;
    #1;
    chk("rdv_before_rst", 64'(avs_readdatavalid), 64'd1);
    rst_n_i = 1'b0;
    #1;
    chk("async_rst_rdv",   64'(avs_readdatavalid), 64'd0);
    chk("async_rst_rdata", 64'(avs_readdata),      64'd0);
    chk("async_rst_valid", 64'(st_valid_o),        64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    rd(2'd1, 32'h0001_0000, "status_post_rst");
    rd(2'd2, 32'h0, "ctrl_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
